// File: rtl/barrel_shifter.sv
// barrel_shifter: registered 64-bit logarithmic shifter for the integer execute stage.
//
// Performs logical left, logical right and arithmetic right shifts by 0..WIDTH-1
// positions with a fixed one-cycle latency and full throughput.
//
// Ports:
//   clk        in   system clock, rising-edge active
//   rst        in   synchronous active-high reset (priority over in_valid)
//   in_valid   in   operands valid this cycle
//   shift      in   unsigned shift amount [SHAMT_W-1:0]
//   sl         in   1 = shift left, 0 = shift right
//   extend_bit in   right shifts: 1 = arithmetic, 0 = logical; ignored on left shifts
//   in         in   operand [WIDTH-1:0]
//   out        out  registered result [WIDTH-1:0]
//   out_valid  out  out holds the result of the op accepted on the previous edge
//
// Right shifts reuse the left-shift core: the operand is bit-reversed, shifted
// left with the fill bit entering at the LSB end of every stage, then reversed
// back. A single mux network therefore serves all three modes.

module barrel_shifter #(
    parameter int unsigned WIDTH   = 64,
    parameter int unsigned SHAMT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [SHAMT_W-1:0] shift,
    input  logic               sl,
    input  logic               extend_bit,
    input  logic [WIDTH-1:0]   in,
    output logic [WIDTH-1:0]   out,
    output logic               out_valid
);

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic logic [WIDTH-1:0] bit_reverse(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            r[i] = v[int'(WIDTH) - 1 - i];
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Combinational core
    // ------------------------------------------------------------------
    logic             fill;
    logic [WIDTH-1:0] core_in;
    logic [WIDTH-1:0] core_out;
    logic [WIDTH-1:0] result;

    // stage[k] is the value entering mux stage k; stage[SHAMT_W] is the core output.
    logic [WIDTH-1:0] stage [SHAMT_W+1];

    // Left shifts always fill with zero; right shifts fill with the sign bit
    // only when an arithmetic shift is requested.
    assign fill = ~sl & extend_bit & in[WIDTH-1];

    always_comb begin
        core_in = sl ? in : bit_reverse(in);
    end

    assign stage[0] = core_in;

    // Stage k shifts by 2^k toward the MSB. The fill bit is injected into the
    // vacated LSBs at every stage so multi-stage arithmetic shifts stay correct.
    for (genvar k = 0; k < int'(SHAMT_W); k++) begin : g_stage
        localparam int unsigned amt = 1 << k;
        assign stage[k+1] = shift[k] ? {stage[k][WIDTH-1-amt:0], {amt{fill}}} : stage[k];
    end

    assign core_out = stage[SHAMT_W];

    always_comb begin
        result = sl ? core_out : bit_reverse(core_out);
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] out_q;
    logic             valid_q;

    // Data only loads on valid cycles, so X on idle inputs never reaches out.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                out_q <= result;
            end
        end
    end

    assign out       = out_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_barrel_shifter.sv
// tb_barrel_shifter: directed and swept self-checking bench for barrel_shifter.

module tb_barrel_shifter;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [5:0]  shift;
    logic        sl;
    logic        extend_bit;
    logic [63:0] data;
    logic [63:0] out;
    logic        out_valid;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    barrel_shifter #(
        .WIDTH   (64),
        .SHAMT_W (6)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .shift      (shift),
        .sl         (sl),
        .extend_bit (extend_bit),
        .in         (data),
        .out        (out),
        .out_valid  (out_valid)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model, written independently of the RTL structure.
    function automatic logic [63:0] ref_shift(input logic [63:0] v, input logic [5:0] sh,
                                              input logic s, input logic e);
        if (s) return v << sh;
        if (e) return 64'($signed(v) >>> sh);
        return v >> sh;
    endfunction

    // Drive one cycle of inputs at the falling edge, return 1ns after the rising edge.
    task automatic drive(input logic v, input logic [63:0] d, input logic [5:0] sh,
                         input logic s, input logic e);
        @(negedge clk);
        in_valid   = v;
        data       = d;
        shift      = sh;
        sl         = s;
        extend_bit = e;
        @(posedge clk);
        #1;
    endtask

    logic [63:0] rnd;
    logic [63:0] exp_q [3];
    logic [63:0] pipe_in [3];
    logic [5:0]  pipe_sh [3];
    logic        pipe_sl [3];
    logic        pipe_ex [3];

    initial begin
        rst = 1'b1; in_valid = 1'b0; data = '0; shift = '0; sl = 1'b0; extend_bit = 1'b0;

        // Reset held for two cycles with in_valid asserted.
        drive(1'b1, 64'hdead_beef_0123_4567, 6'd5, 1'b1, 1'b0);
        check("rst0_out", out, 64'h0);
        check("rst0_vld", {63'h0, out_valid}, 64'h0);
        drive(1'b1, 64'hdead_beef_0123_4567, 6'd5, 1'b1, 1'b0);
        check("rst1_out", out, 64'h0);
        check("rst1_vld", {63'h0, out_valid}, 64'h0);

        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 64'h0, 6'd0, 1'b0, 1'b0);
        check("idle_vld", {63'h0, out_valid}, 64'h0);

        // First op after reset release.
        drive(1'b1, 64'h0000_0000_ffff_ffff, 6'd15, 1'b0, 1'b1);
        check("lsr_pos_vld", {63'h0, out_valid}, 64'h1);
        check("lsr_pos", out, 64'h0000_0000_0001_ffff);

        drive(1'b1, 64'h8000_0000_0000_0000, 6'd15, 1'b0, 1'b1);
        check("asr_neg", out, 64'hffff_0000_0000_0000);
        drive(1'b1, 64'h8000_0000_0000_0000, 6'd15, 1'b0, 1'b0);
        check("lsr_neg", out, 64'h0001_0000_0000_0000);

        drive(1'b1, 64'h1, 6'd63, 1'b1, 1'b1);
        check("sll_63", out, 64'h8000_0000_0000_0000);
        drive(1'b1, 64'hffff_ffff_ffff_ffff, 6'd4, 1'b1, 1'b1);
        check("sll_4", out, 64'hffff_ffff_ffff_fff0);

        // shift = 0 is identity in every mode.
        for (int m = 0; m < 4; m++) begin
            drive(1'b1, 64'hdead_beef_0123_4567, 6'd0, m[1], m[0]);
            check($sformatf("sh0_m%0d", m), out, 64'hdead_beef_0123_4567);
        end

        // shift = 63 boundaries.
        drive(1'b1, 64'h8000_0000_0000_0000, 6'd63, 1'b0, 1'b1);
        check("asr_63", out, 64'hffff_ffff_ffff_ffff);
        drive(1'b1, 64'h8000_0000_0000_0001, 6'd63, 1'b0, 1'b0);
        check("lsr_63", out, 64'h0000_0000_0000_0001);
        drive(1'b1, 64'h7fff_ffff_ffff_ffff, 6'd63, 1'b0, 1'b1);
        check("asr_63_pos", out, 64'h0);

        // Back-to-back ops then a bubble.
        pipe_in[0] = 64'h0123_4567_89ab_cdef; pipe_sh[0] = 6'd8;  pipe_sl[0] = 1'b1; pipe_ex[0] = 1'b0;
        pipe_in[1] = 64'hf000_0000_0000_0000; pipe_sh[1] = 6'd4;  pipe_sl[1] = 1'b0; pipe_ex[1] = 1'b1;
        pipe_in[2] = 64'hf000_0000_0000_0000; pipe_sh[2] = 6'd32; pipe_sl[2] = 1'b0; pipe_ex[2] = 1'b0;
        exp_q[0] = 64'h2345_6789_abcd_ef00;
        exp_q[1] = 64'hff00_0000_0000_0000;
        exp_q[2] = 64'h0000_0000_f000_0000;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, pipe_in[i], pipe_sh[i], pipe_sl[i], pipe_ex[i]);
            check($sformatf("pipe%0d_vld", i), {63'h0, out_valid}, 64'h1);
            check($sformatf("pipe%0d", i), out, exp_q[i]);
        end
        drive(1'b0, 64'h5555_5555_5555_5555, 6'd1, 1'b1, 1'b0);
        check("bubble_vld", {63'h0, out_valid}, 64'h0);
        check("bubble_hold", out, exp_q[2]);
        drive(1'b0, 64'haaaa_aaaa_aaaa_aaaa, 6'd3, 1'b0, 1'b1);
        check("bubble2_hold", out, exp_q[2]);

        // Reset asserted with an op in flight discards it.
        drive(1'b1, 64'h1234, 6'd4, 1'b1, 1'b0);
        check("pre_rst", out, 64'h12340);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; data = 64'hffff; shift = 6'd1; sl = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_vld", {63'h0, out_valid}, 64'h0);
        check("mid_rst_out", out, 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // Sweep all shift amounts in all three modes against the model.
        for (int sh = 0; sh < 64; sh++) begin
            for (int m = 0; m < 3; m++) begin
                rnd = {$urandom(), $urandom()};
                if (sh[0]) rnd[63] = 1'b1;
                case (m)
                    0: begin
                        drive(1'b1, rnd, 6'(sh), 1'b1, sh[1]);
                        check($sformatf("sweep_sll_%0d", sh), out, ref_shift(rnd, 6'(sh), 1'b1, 1'b0));
                    end
                    1: begin
                        drive(1'b1, rnd, 6'(sh), 1'b0, 1'b0);
                        check($sformatf("sweep_lsr_%0d", sh), out, ref_shift(rnd, 6'(sh), 1'b0, 1'b0));
                    end
                    default: begin
                        drive(1'b1, rnd, 6'(sh), 1'b0, 1'b1);
                        check($sformatf("sweep_asr_%0d", sh), out, ref_shift(rnd, 6'(sh), 1'b0, 1'b1));
                    end
                endcase
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/barrel_shifter.md
Name: barrel_shifter

Overview:
- 64-bit logarithmic barrel shifter used in the integer execute stage next to the adder and multiplier.
- Performs logical left, logical right and arithmetic right shifts by 0–63 positions.
- Output is registered: one-cycle latency with a valid strobe.
- Combinational core is a 6-stage mux network with shifts of 1, 2, 4, 8, 16 and 32 positions.

Parameters:
- WIDTH, 64, data width in bits; must be a power of two.
- SHAMT_W, 6, shift-amount width; equals log2(WIDTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands are valid this cycle.
- shift  input  SHAMT_W  shift amount, unsigned. Callers with wider amounts pass only the low SHAMT_W bits.
- sl  input  1  direction: 1 = shift left, 0 = shift right.
- extend_bit  input  1  right shifts only: 1 = arithmetic (fill with in[WIDTH-1]), 0 = logical (fill with 0). Ignored when sl=1.
- in  input  WIDTH  operand to shift.
- out  output  WIDTH  registered shift result.
- out_valid  output  1  out holds the result of the operation accepted in the previous cycle.

Behaviour:
- Reset: on a rising clk edge with rst=1, out <= 0 and out_valid <= 0. rst has priority over in_valid.
- Latency: exactly 1 cycle. Operands sampled at edge N with in_valid=1 produce out and out_valid=1 after edge N.
- Throughput: one operation per cycle, fully pipelined. No backpressure or stall input.
- in_valid=0 at an edge: out_valid <= 0 and out holds its previous value.
- Fill bit: fill = (~sl) & extend_bit & in[WIDTH-1].
- Left shift (sl=1): out = (in << shift) mod 2^WIDTH. Vacated LSBs are 0.
- Right shift (sl=0): out[i] = in[i+shift] for i+shift < WIDTH, else fill.
- shift=0: out = in for all sl/extend_bit combinations.
- shift=WIDTH-1:
  - left: out = {in[0], 0...}.
  - logical right: out = {0..., in[WIDTH-1]}.
  - arithmetic right: every bit equals in[WIDTH-1].
- Structure:
  - Right shifts are produced either by bit-reversing around a left-shift core or by a dedicated right network.
  - Stage k shifts by 2^k when shift[k]=1.
  - Fill must be injected at every stage, not only the last.
- No X propagation: all outputs are defined from reset onward regardless of input X on non-valid cycles. Gate the register enable on in_valid.
- Reset asserted mid-stream: the in-flight result is discarded and out_valid is 0 on the next cycle.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1 → out=0, out_valid=0. Release rst → the first valid op appears one cycle after it is accepted.
- Logical right with extend set, non-negative input: in=64'h0000_0000_ffff_ffff, shift=15, sl=0, extend_bit=1 → out=64'h0000_0000_0001_ffff, equal to in >> 15.
- Arithmetic vs logical right on a negative input: in=64'h8000_0000_0000_0000, shift=15, sl=0.
  - extend_bit=1 → out=64'hffff_0000_0000_0000.
  - extend_bit=0 → out=64'h0001_0000_0000_0000.
- Left shift, extend ignored: in=64'h1, shift=63, sl=1, extend_bit=1 → out=64'h8000_0000_0000_0000. Repeat with in=64'hffff_ffff_ffff_ffff, shift=4 → out=64'hffff_ffff_ffff_fff0.
- Boundaries: shift=0 with in=64'hdead_beef_0123_4567 → out equals in for all 4 sl/extend combinations. Arithmetic right of 64'h8000_0000_0000_0000 by 63 → out=all ones.
- Back-to-back pipelining: 3 consecutive valid ops with in_valid=1 every cycle, then one bubble (in_valid=0) → out_valid pattern 1,1,1,0, results in order, out held during the bubble.
- Sweep: all 64 shift amounts × 3 modes on random in, compared against a reference model.
